// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared constants and types for the sprite line fetcher.
//   - TRANSPARENT_IDX / TRANSPARENT_WORD : palette index and word that
//     mean "no sprite pixel here".
//   - fill_state_t : line-buffer fill FSM states.
//   - ADDR_W / COORD_W / DATA_W : SRAM address, screen coordinate and
//     SRAM word widths.
//   - idx_w()    : width of a word index for a buffer of a given depth.
//   - pal_word() : packs an 8-bit palette index into the 16-bit word
//     that the palette stage expects.
package sprite_pkg;

    localparam int ADDR_W  = 20;
    localparam int COORD_W = 10;
    localparam int DATA_W  = 16;

    localparam logic [7:0]  TRANSPARENT_IDX  = 8'hFF;
    localparam logic [15:0] TRANSPARENT_WORD = 16'h00FF;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // A depth of 1 still needs a 1-bit index so that no port collapses
    // to zero width.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [15:0] pal_word(input logic [7:0] idx);
        return {8'h00, idx};
    endfunction

endpackage

// File: rtl/sprite_line_buf.sv
// sprite_line_buf
//   Two-bank (ping-pong) sprite line buffer.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset (valid bits)
//     wr_en, wr_bank,     synchronous write of one SRAM word into
//     wr_idx, wr_data     bank wr_bank, slot wr_idx
//     set_vld             mark bank wr_bank valid (last word of a fill)
//     clr_en, clr_bank    mark bank clr_bank invalid (clear wins over set)
//     rd_bank, rd_idx     asynchronous read address
//     rd_data             word at {rd_bank, rd_idx}
//     bank_vld            per-bank valid bits
module sprite_line_buf
    import sprite_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int IW   = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [IW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              set_vld,
    input  logic              clr_en,
    input  logic              clr_bank,
    input  logic              rd_bank,
    input  logic [IW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        bank_vld
);

    // Slot count is rounded up to a power of two so that every index value
    // is in range; slots at or above DEPTH are never written, and the
    // display path never trusts what it reads outside the sprite span.
    localparam int SLOTS = 1 << IW;

    logic [1:0][SLOTS-1:0][DATA_W-1:0] mem;

    // Data storage needs no reset: a bank's contents are only looked at
    // while its valid bit is set, and that only happens after a full fill.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    // Clear is written last so it takes priority if both hit one bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_vld <= 2'b00;
        end else begin
            if (set_vld) begin
                bank_vld[wr_bank] <= 1'b1;
            end
            if (clr_en) begin
                bank_vld[clr_bank] <= 1'b0;
            end
        end
    end

    assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/sprite_line_fetch.sv
// sprite_line_fetch
//   Fetches the sprite row for the upcoming scanline from SRAM into the
//   fill bank of a ping-pong line buffer during horizontal blank, and
//   streams palette words for the current line out of the display bank.
//   Ports:
//     Clk, Reset          clock; asynchronous active-high reset
//     line_start          1-cycle pulse at start of horizontal blank
//     next_line           scanline shown after this blank (with line_start)
//     sprite_x, sprite_y  sprite top-left, sampled at line_start
//     DrawX               current pixel column
//     rd_req, rd_addr     SRAM read request / word address
//     rd_ack, rd_data     arbiter grant, read data valid with the grant
//     color               {8'h00, index}, 16'h00FF when transparent
//     sprite_on           pixel inside sprite and index not transparent
//     overrun             sticky: a fill was cut short by line_start
module sprite_line_fetch
    import sprite_pkg::*;
#(
    parameter int                SPR_W     = 32,
    parameter int                SPR_H     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 20'h00000
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               line_start,
    input  logic [COORD_W-1:0] next_line,
    input  logic [COORD_W-1:0] sprite_x,
    input  logic [COORD_W-1:0] sprite_y,
    input  logic [COORD_W-1:0] DrawX,
    output logic               rd_req,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_ack,
    input  logic [DATA_W-1:0]  rd_data,
    output logic [DATA_W-1:0]  color,
    output logic               sprite_on,
    output logic               overrun
);

    localparam int                 WORDS    = SPR_W / 2;
    localparam int                 IW       = idx_w(WORDS);
    localparam logic [IW-1:0]      LAST_IDX = IW'(WORDS - 1);
    localparam logic [COORD_W:0]   SPR_W_C  = (COORD_W + 1)'(SPR_W);

    fill_state_t        state;
    logic [IW-1:0]      word_idx;
    logic               disp_sel;
    logic [COORD_W-1:0] disp_x;

    // ------------------------------------------------------------------
    // Fill side
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] row;
    logic               row_hit;
    logic [ADDR_W-1:0]  row_base;
    logic               last_word;
    logic               ack_take;

    // row wraps when next_line < sprite_y, so the >= check is what rejects
    // lines above the sprite.
    assign row      = next_line - sprite_y;
    assign row_hit  = (next_line >= sprite_y) && ({22'd0, row} < 32'(SPR_H));
    assign row_base = BASE_ADDR + ADDR_W'(row) * ADDR_W'(WORDS);

    assign last_word = (word_idx == LAST_IDX);
    // An ack landing on line_start belongs to the aborted fill: drop it.
    assign ack_take  = (state == FILL) && rd_ack && !line_start;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            word_idx <= '0;
            rd_addr  <= '0;
            disp_sel <= 1'b0;
            disp_x   <= '0;
            overrun  <= 1'b0;
        end else if (line_start) begin
            disp_sel <= ~disp_sel;
            disp_x   <= sprite_x;
            word_idx <= '0;
            if (state == FILL) begin
                overrun <= 1'b1;
            end
            if (row_hit) begin
                state   <= FILL;
                rd_addr <= row_base;
            end else begin
                state   <= IDLE;
            end
        end else if (ack_take) begin
            if (last_word) begin
                state <= IDLE;
            end else begin
                // rd_addr tracks word_idx so it only moves after an ack.
                word_idx <= word_idx + IW'(1);
                rd_addr  <= rd_addr + ADDR_W'(1);
            end
        end
    end

    assign rd_req = (state == FILL);

    // ------------------------------------------------------------------
    // Line buffer
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] col;
    logic [DATA_W-1:0]  buf_word;
    logic [1:0]         bank_vld;

    assign col = DrawX - disp_x;

    // The fill bank is always the one not on display. On line_start the
    // banks swap, so the bank being cleared is the current display bank,
    // which becomes the new fill bank.
    sprite_line_buf #(
        .DEPTH (WORDS)
    ) u_buf (
        .clk      (Clk),
        .rst      (Reset),
        .wr_en    (ack_take),
        .wr_bank  (~disp_sel),
        .wr_idx   (word_idx),
        .wr_data  (rd_data),
        .set_vld  (ack_take && last_word),
        .clr_en   (line_start),
        .clr_bank (disp_sel),
        .rd_bank  (disp_sel),
        .rd_idx   (col[IW:1]),
        .rd_data  (buf_word),
        .bank_vld (bank_vld)
    );

    // ------------------------------------------------------------------
    // Display side
    // ------------------------------------------------------------------
    logic       hit;
    logic [7:0] pix;

    // DrawX >= disp_x guards against col wrapping into range when the
    // sprite sits near the right edge of the coordinate space.
    assign hit = (DrawX >= disp_x) && ({1'b0, col} < SPR_W_C) && bank_vld[disp_sel];
    assign pix = col[0] ? buf_word[15:8] : buf_word[7:0];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            color     <= TRANSPARENT_WORD;
            sprite_on <= 1'b0;
        end else begin
            color     <= hit ? pal_word(pix) : TRANSPARENT_WORD;
            sprite_on <= hit && (pix != TRANSPARENT_IDX);
        end
    end

endmodule

// File: tb/tb_sprite_line_fetch.sv
module tb_sprite_line_fetch;

    localparam int          W     = 32;
    localparam int          H     = 32;
    localparam int          WORDS = W / 2;
    localparam logic [19:0] BASE  = 20'h00100;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        line_start = 1'b0;
    logic        rd_ack = 1'b0;
    logic [9:0]  next_line = '0, sprite_x = '0, sprite_y = '0, DrawX = '0;
    logic        rd_req, sprite_on, overrun;
    logic [19:0] rd_addr;
    logic [15:0] rd_data, color;

    int n_cmp = 0;
    int n_bad = 0;

    sprite_line_fetch #(.SPR_W(W), .SPR_H(H), .BASE_ADDR(BASE)) dut (
        .Clk(Clk), .Reset(Reset), .line_start(line_start), .next_line(next_line),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .DrawX(DrawX),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .color(color), .sprite_on(sprite_on), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    // SRAM image: two hand-picked words at the start of row 0, a
    // recognisable pattern everywhere else.
    function automatic logic [15:0] sram(input logic [19:0] a);
        if (a == BASE)         return 16'hAB12;
        if (a == BASE + 20'd1) return 16'hFF05;
        return {~a[7:0], a[7:0]};
    endfunction

    assign rd_data = sram(rd_addr);

    // Palette index of sprite pixel (r, c) straight from the SRAM image.
    function automatic logic [7:0] pixel(input int r, input int c);
        logic [15:0] w;
        w = sram(BASE + 20'(r * WORDS + c / 2));
        return (c % 2 == 1) ? w[15:8] : w[7:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: a line fetch is a transaction of WORDS acks started by an
    // in-range line_start; a line shows the sprite only if the fetch
    // issued during the blank before it completed.
    // ------------------------------------------------------------------
    bit          m_fill, m_fvalid, m_dvalid, m_ovr;
    int          m_acks, m_frow, m_drow, m_dx;
    logic [15:0] e_color;
    bit          e_on, e_req;
    logic [19:0] e_addr;

    always @(posedge Clk) begin
        int  col;
        int  row;
        logic [7:0] b;
        if (Reset) begin
            m_fill = 0; m_fvalid = 0; m_dvalid = 0; m_ovr = 0;
            m_acks = 0; m_frow = 0; m_drow = 0; m_dx = 0;
            e_color = 16'h00FF; e_on = 0; e_req = 0; e_addr = '0;
        end else begin
            col = int'({22'd0, DrawX}) - m_dx;
            if (m_dvalid && col >= 0 && col < W) begin
                b = pixel(m_drow, col);
                e_color = {8'h00, b};
                e_on = (b != 8'hFF);
            end else begin
                e_color = 16'h00FF;
                e_on = 0;
            end
            if (line_start) begin
                if (m_fill) m_ovr = 1;
                m_dvalid = m_fvalid;
                m_drow   = m_frow;
                m_dx     = int'({22'd0, sprite_x});
                row      = int'({22'd0, next_line}) - int'({22'd0, sprite_y});
                m_fvalid = 0;
                m_fill   = (row >= 0 && row < H);
                m_acks   = 0;
                m_frow   = row;
            end else if (m_fill && rd_ack) begin
                m_acks++;
                if (m_acks == WORDS) begin
                    m_fill = 0;
                    m_fvalid = 1;
                end
            end
            e_req  = m_fill;
            e_addr = BASE + 20'(m_frow * WORDS + m_acks);
        end
    end

    always @(negedge Clk) begin
        if (Reset) begin
            chk("rst_req",   32'(rd_req),    32'd0);
            chk("rst_color", 32'(color),     32'h00FF);
            chk("rst_on",    32'(sprite_on), 32'd0);
            chk("rst_ovr",   32'(overrun),   32'd0);
        end else begin
            chk("req", 32'(rd_req), 32'(e_req));
            if (e_req) chk("addr", 32'(rd_addr), 32'(e_addr));
            chk("color",   32'(color),     32'(e_color));
            chk("on",      32'(sprite_on), 32'(e_on));
            chk("overrun", 32'(overrun),   32'(m_ovr));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ls(input int nl, input int x, input int y);
        line_start = 1'b1;
        next_line  = 10'(nl);
        sprite_x   = 10'(x);
        sprite_y   = 10'(y);
        tick();
        line_start = 1'b0;
    endtask

    task automatic px(input string nm, input int x, input logic [15:0] c, input bit on);
        DrawX = 10'(x);
        tick();
        chk({nm, "_color"}, 32'(color), 32'(c));
        chk({nm, "_on"},    32'(sprite_on), 32'(on));
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;

        // Reset in the middle of a fill
        rd_ack = 1'b0;
        ls(100, 200, 100);
        chk("A_req",   32'(rd_req),  32'd1);
        chk("A_addr0", 32'(rd_addr), 32'(BASE));
        tick(); tick();
        Reset = 1'b1;
        #1;
        chk("A_async_req",   32'(rd_req), 32'd0);
        chk("A_async_color", 32'(color),  32'h00FF);
        tick(); tick();
        Reset  = 1'b0;
        rd_ack = 1'b1;
        repeat (5) tick();
        chk("A_no_req_after", 32'(rd_req), 32'd0);
        ls(101, 200, 100);
        px("A_invalid", 200, 16'h00FF, 0);
        repeat (16) tick();

        // Row 0 fetch with rd_ack held high
        ls(100, 200, 100);
        chk("B_addr0", 32'(rd_addr), 32'(BASE));
        repeat (15) tick();
        chk("B_req15",  32'(rd_req),  32'd1);
        chk("B_addr15", 32'(rd_addr), 32'(BASE + 20'd15));
        tick();
        chk("B_req_done", 32'(rd_req), 32'd0);
        ls(101, 200, 100);
        px("B_col0",  200, 16'h0012, 1);
        px("B_col1",  201, 16'h00AB, 1);
        px("B_col2",  202, 16'h0005, 1);
        px("B_col3",  203, 16'h00FF, 0);
        px("B_left",  199, 16'h00FF, 0);
        px("B_right", 232, 16'h00FF, 0);
        px("B_col31", 231, 16'h00F0, 1);
        repeat (12) tick();

        // Last sprite row, then first row past the sprite
        ls(131, 200, 100);
        chk("C_addr496", 32'(rd_addr), 32'(BASE + 20'd496));
        repeat (15) tick();
        chk("C_addr511", 32'(rd_addr), 32'(BASE + 20'd511));
        tick();
        ls(132, 200, 100);
        chk("C_no_req", 32'(rd_req), 32'd0);
        px("C_row31", 200, 16'h00F0, 1);
        ls(133, 200, 100);
        px("C_empty", 210, 16'h00FF, 0);

        // Slow arbiter: fill cut short by the next line_start
        chk("D_ovr_pre", 32'(overrun), 32'd0);
        ls(110, 200, 100);
        for (int i = 0; i < 30; i++) begin
            rd_ack = (i % 4 == 3);
            tick();
        end
        rd_ack = 1'b1;
        ls(300, 200, 100);
        rd_ack = 1'b0;
        chk("D_ovr", 32'(overrun), 32'd1);
        chk("D_req", 32'(rd_req),  32'd0);
        px("D_aborted", 205, 16'h00FF, 0);

        // Sprite near the right edge of coordinate space
        rd_ack = 1'b1;
        ls(100, 1000, 100);
        repeat (16) tick();
        ls(101, 1000, 100);
        px("E_wrap",  5,    16'h00FF, 0);
        px("E_col0",  1000, 16'h0012, 1);
        px("E_col23", 1023, 16'h00F4, 1);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
